// File: rtl/nor_selftest_pkg.sv
// Shared definitions for the bitwise-unit self-test engines: FSM state encoding
// and the golden function that each sibling engine swaps out.
package nor_selftest_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } st_e;

  localparam int GOLD_MAX_W = 32;

  function automatic logic [GOLD_MAX_W-1:0] golden_op(
    input logic [GOLD_MAX_W-1:0] a,
    input logic [GOLD_MAX_W-1:0] b
  );
    return ~(a | b);
  endfunction

  // Compares only the low w bits, so operands can be zero-extended freely.
  function automatic logic golden_miss(
    input logic [GOLD_MAX_W-1:0] a,
    input logic [GOLD_MAX_W-1:0] b,
    input logic [GOLD_MAX_W-1:0] res,
    input int                    w
  );
    logic [GOLD_MAX_W-1:0] mask;
    mask = (w >= GOLD_MAX_W) ? '1 : ((GOLD_MAX_W'(1) << w) - GOLD_MAX_W'(1));
    return |((golden_op(a, b) ^ res) & mask);
  endfunction

endpackage

// File: rtl/nor_selftest_driver_op_sweep_counter.sv
// Nested operand counter: op2 is the fast digit, op1 steps when op2 wraps.
module op_sweep_counter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_adv,
  output logic [WIDTH-1:0] o_op1,
  output logic [WIDTH-1:0] o_op2,
  output logic             o_last
);

  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_op2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op1 <= '0;
      r_op2 <= '0;
    end else if (i_clr) begin
      r_op1 <= '0;
      r_op2 <= '0;
    end else if (i_adv) begin
      r_op2 <= r_op2 + WIDTH'(1);
      if (&r_op2) r_op1 <= r_op1 + WIDTH'(1);
    end
  end

  assign o_op1  = r_op1;
  assign o_op2  = r_op2;
  assign o_last = (&r_op1) & (&r_op2);

endmodule

// File: rtl/nor_selftest_driver.sv
// Exhaustive self-test engine for a WIDTH-bit NOR unit: sweeps all operand pairs,
// checks each result after SETTLE cycles, and records error count and first failure.
module nor_selftest_driver
  import nor_selftest_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_op1,
  output logic [WIDTH-1:0] o_op2,
  input  logic [WIDTH-1:0] i_res,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_fail,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [WIDTH-1:0] o_first_op1,
  output logic [WIDTH-1:0] o_first_op2,
  output logic [WIDTH-1:0] o_first_res
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  st_e              r_state;
  st_e              w_nxt;
  logic [SW-1:0]    r_settle;
  logic             w_clr;
  logic             w_adv;
  logic             w_load;
  logic             w_check;
  logic             w_last;
  logic             w_miss;
  logic             r_fail;
  logic [CNT_W-1:0] r_err_cnt;
  logic [WIDTH-1:0] r_first_op1;
  logic [WIDTH-1:0] r_first_op2;
  logic [WIDTH-1:0] r_first_res;

  op_sweep_counter #(.WIDTH(WIDTH)) u_sweep (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_adv   (w_adv),
    .o_op1   (o_op1),
    .o_op2   (o_op2),
    .o_last  (w_last)
  );

  assign w_miss = golden_miss(GOLD_MAX_W'(o_op1), GOLD_MAX_W'(o_op2),
                              GOLD_MAX_W'(i_res), WIDTH);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    w_clr   = 1'b0;
    w_adv   = 1'b0;
    w_load  = 1'b0;
    w_check = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_nxt  = ST_WAIT;
          w_clr  = 1'b1;
          w_load = 1'b1;
        end
      end
      ST_WAIT: begin
        if (r_settle == '0) w_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        w_check = 1'b1;
        if (w_last) begin
          w_nxt = ST_DONE;
        end else begin
          w_nxt  = ST_WAIT;
          w_adv  = 1'b1;
          w_load = 1'b1;
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  // Loaded with SETTLE-1 so WAIT lasts exactly SETTLE cycles before CHECK.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_settle <= '0;
    end else if (w_load) begin
      r_settle <= SW'(SETTLE - 1);
    end else if (r_state == ST_WAIT && r_settle != '0) begin
      r_settle <= r_settle - SW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fail      <= 1'b0;
      r_err_cnt   <= '0;
      r_first_op1 <= '0;
      r_first_op2 <= '0;
      r_first_res <= '0;
    end else if (w_clr) begin
      r_fail      <= 1'b0;
      r_err_cnt   <= '0;
      r_first_op1 <= '0;
      r_first_op2 <= '0;
      r_first_res <= '0;
    end else if (w_check && w_miss) begin
      if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + CNT_W'(1);
      if (!r_fail) begin
        r_fail      <= 1'b1;
        r_first_op1 <= o_op1;
        r_first_op2 <= o_op2;
        r_first_res <= i_res;
      end
    end
  end

  assign o_busy      = (r_state == ST_WAIT) || (r_state == ST_CHECK);
  assign o_done      = (r_state == ST_DONE);
  assign o_fail      = r_fail;
  assign o_err_cnt   = r_err_cnt;
  assign o_first_op1 = r_first_op1;
  assign o_first_op2 = r_first_op2;
  assign o_first_res = r_first_res;

endmodule
